// File: rtl/alu_op_stack.sv
// alu_op_stack: DEPTH-entry operand stack feeding an external ALU op.
// Optional synchronous flush port i_clear under ALU_OP_STACK_CLR_EN.
module alu_op_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_combine,
  input  logic             i_result_ready,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  input  logic [WIDTH-1:0] i_op_result,
`ifdef ALU_OP_STACK_CLR_EN
  input  logic             i_clear,
`endif
  output logic [CW-1:0]    o_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    push_idx;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic             data_fire;
  logic             fold;
  logic             pop;
  logic             clr;

`ifdef ALU_OP_STACK_CLR_EN
  assign clr = i_clear;
`else
  assign clr = 1'b0;
`endif

  // Top-of-stack view and handshake qualifiers
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign top_idx   = IW'(count_q - CW'(1));
  assign push_idx  = IW'(count_q);
  assign top       = empty ? '0 : mem[top_idx];
  assign data_fire = i_data_valid && o_data_ready;
  assign fold      = i_combine && !empty;
  assign pop       = o_result_valid && i_result_ready;

  assign o_data_ready   = !full || fold;
  assign o_result_valid = !empty && !i_data_valid;
  assign o_result       = top;
  assign o_op_a         = i_data;
  assign o_op_b         = top;
  assign o_count        = count_q;

  // Stack update: flush beats data, data beats pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      priority case (1'b1)
        clr: begin
          count_q <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end
        data_fire && fold: begin
          mem[top_idx] <= i_op_result;
        end
        data_fire: begin
          mem[push_idx] <= i_data;
          count_q       <= count_q + CW'(1);
        end
        pop: begin
          mem[top_idx] <= '0;
          count_q      <= count_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_stack.sv
// tb_alu_op_stack: queue model compared every cycle, plus directed
// literal checks of push/pop/combine/full/priority/reset behaviour.
module tb_alu_op_stack;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dvalid;
  logic         dready;
  logic [W-1:0] data;
  logic         comb;
  logic         rready;
  logic         rvalid;
  logic [W-1:0] res;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] op_res;
  logic [2:0]   cnt;
  logic         clr;

  int nvec = 0;
  int nmis = 0;

  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  assign op_res = op_a + op_b;

  alu_op_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data_valid(dvalid),
    .o_data_ready(dready),
    .i_data(data),
    .i_combine(comb),
    .i_result_ready(rready),
    .o_result_valid(rvalid),
    .o_result(res),
    .o_op_a(op_a),
    .o_op_b(op_b),
    .i_op_result(op_res),
`ifdef ALU_OP_STACK_CLR_EN
    .i_clear(clr),
`endif
    .o_count(cnt)
  );

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (q.size() == 0) ? '0 : q[q.size()-1];
  endfunction

  function automatic logic m_ready();
    return (q.size() < D) || (comb && q.size() != 0);
  endfunction

  function automatic logic m_valid();
    return (q.size() != 0) && !dvalid;
  endfunction

  // Reference stack as a plain queue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
`ifdef ALU_OP_STACK_CLR_EN
      if (clr) q.delete();
      else
`endif
      if (dvalid && m_ready()) begin
        if (comb && q.size() != 0) q[q.size()-1] = q[q.size()-1] + data;
        else q.push_back(data);
      end else if (m_valid() && rready) begin
        void'(q.pop_back());
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_count", W'(cnt), W'(q.size()));
    chk("m_ready", W'(dready), W'(m_ready()));
    chk("m_valid", W'(rvalid), W'(m_valid()));
    chk("m_result", res, m_top());
    chk("m_op_b", op_b, m_top());
    chk("m_op_a", op_a, data);
  end

  task automatic cyc(logic v, logic [W-1:0] d, logic c, logic r);
    @(posedge clk);
    #1;
    dvalid = v;
    data   = d;
    comb   = c;
    rready = r;
  endtask

  initial begin
    rst_n = 1'b0;
    dvalid = 1'b0;
    data = '0;
    comb = 1'b0;
    rready = 1'b0;
    clr = 1'b0;
    #3;
    chk("rst_count", W'(cnt), 0);
    chk("rst_ready", W'(dready), 1);
    chk("rst_valid", W'(rvalid), 0);
    chk("rst_result", res, 0);
    chk("rst_op_b", op_b, 0);
    #9;
    rst_n = 1'b1;

    // push 5, 7 then pop twice
    cyc(1, 5, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(0, 0, 0, 1);
    #1;
    chk("pp_top7", res, 7);
    chk("pp_cnt2", W'(cnt), 2);
    cyc(0, 0, 0, 1);
    #1;
    chk("pp_top5", res, 5);
    chk("pp_cnt1", W'(cnt), 1);
    cyc(0, 0, 0, 0);
    #1;
    chk("pp_cnt0", W'(cnt), 0);
    chk("pp_valid0", W'(rvalid), 0);

    // push 10, fold 3 with add
    cyc(1, 10, 0, 0);
    cyc(1, 3, 1, 0);
    #1;
    chk("cb_op_a", op_a, 3);
    chk("cb_op_b", op_b, 10);
    cyc(0, 0, 0, 0);
    #1;
    chk("cb_top13", res, 32'd13);
    chk("cb_cnt1", W'(cnt), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    #1;
    chk("cb_cnt0", W'(cnt), 0);

    // fill, stall push, pop blocked by data, fold at full
    for (int i = 1; i <= D; i++) cyc(1, W'(i), 0, 0);
    cyc(1, 99, 0, 0);
    #1;
    chk("fl_cnt4", W'(cnt), 4);
    chk("fl_ready0", W'(dready), 0);
    cyc(1, 99, 0, 1);
    #1;
    chk("fl_stall_cnt", W'(cnt), 4);
    chk("fl_stall_valid", W'(rvalid), 0);
    chk("fl_stall_ready", W'(dready), 0);
    cyc(1, 6, 1, 0);
    #1;
    chk("fl_cnt_kept", W'(cnt), 4);
    chk("fl_ready_comb", W'(dready), 1);
    cyc(0, 0, 0, 0);
    #1;
    chk("fl_top10", res, 32'd10);
    chk("fl_cnt4b", W'(cnt), 4);

    // data beats pop at count 2
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 55, 0, 1);
    #1;
    chk("pr_cnt2", W'(cnt), 2);
    chk("pr_valid0", W'(rvalid), 0);
    cyc(0, 0, 0, 0);
    #1;
    chk("pr_cnt3", W'(cnt), 3);
    chk("pr_top55", res, 32'd55);

    // async reset mid-stream at count 3
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt0", W'(cnt), 0);
    chk("ar_valid0", W'(rvalid), 0);
    chk("ar_op_b0", op_b, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

`ifdef ALU_OP_STACK_CLR_EN
    // flush overrides a simultaneous push
    cyc(1, 21, 0, 0);
    cyc(1, 22, 0, 0);
    cyc(1, 23, 0, 0);
    cyc(1, 24, 0, 0);
    clr = 1'b1;
    #1;
    chk("cl_cnt3", W'(cnt), 3);
    chk("cl_ready", W'(dready), 1);
    cyc(0, 0, 0, 0);
    clr = 1'b0;
    #1;
    chk("cl_cnt0", W'(cnt), 0);
    chk("cl_op_b0", op_b, 0);
`endif

    cyc(1, 32'hdead_beef, 0, 0);
    cyc(0, 0, 0, 1);
    #1;
    chk("end_top", res, 32'hdead_beef);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #1;
    chk("end_cnt0", W'(cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
